// File: rtl/elevator_call_panel.sv
`default_nettype none
// ============================================================================
// Module   : elevator_call_panel
// Purpose  : Captures floor-button presses as pending calls and offers them
//            round-robin to the car over valid/ack; registers hold/lock.
//            Optional input debounce: define CALL_PANEL_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 4,
  parameter int FLOOR_W         = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_i,
  input  logic                  hold_btn_i,
  input  logic                  key_lock_i,
  input  logic                  call_ack_i,
  output logic                  call_valid_o,
  output logic [FLOOR_W-1:0]    call_floor_o,
  output logic [NUM_FLOORS-1:0] call_lamp_o,
  output logic                  hold_o,
  output logic                  lock_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [FLOOR_W-1:0]    c_last_floor = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] c_one        = NUM_FLOORS'(1);

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 || (1 << FLOOR_W) < NUM_FLOORS ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > ((1 << CNT_W) - 1)) begin : g_param_check
    $error("elevator_call_panel: illegal parameter combination");
  end

  // Bit NUM_FLOORS carries the hold button alongside the floor buttons.
  logic [NUM_FLOORS:0] raw_w;
  logic [NUM_FLOORS:0] filt_w;

  assign raw_w = {hold_btn_i, btn_i};

`ifdef CALL_PANEL_DEBOUNCE_EN
  for (genvar i = 0; i <= NUM_FLOORS; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (raw_w[i] != lvl_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d = raw_w[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign filt_w[i] = lvl_q;
  end
`else
  assign filt_w = raw_w;
`endif

  // First requesting floor at or above ptr, wrapping past the top floor.
  function automatic logic [FLOOR_W-1:0] rr_pick(input logic [NUM_FLOORS-1:0] req,
                                                 input logic [FLOOR_W-1:0]    ptr);
    logic [FLOOR_W-1:0] sel;
    int                 idx;
    sel = '0;
    for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FLOORS) idx = idx - NUM_FLOORS;
      if (req[idx]) sel = idx[FLOOR_W-1:0];
    end
    return sel;
  endfunction

  state_t                  state_q, state_d;
  logic                    call_valid_q, call_valid_d;
  logic [FLOOR_W-1:0]      call_floor_q, call_floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_FLOORS-1:0]   btn_q;
  logic                    hold_q, hold_d;
  logic                    lock_q;
  logic [NUM_FLOORS-1:0]   rise_w;

  assign rise_w = filt_w[NUM_FLOORS-1:0] & ~btn_q;
  assign hold_d = filt_w[NUM_FLOORS] & ~key_lock_i;

  always_comb begin
    state_d      = state_q;
    call_valid_d = call_valid_q;
    call_floor_d = call_floor_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;

    case (state_q)
      IDLE: begin
        if (key_lock_i) begin
          state_d = LOCKED;
        end else if (|pending_q) begin
          call_floor_d = rr_pick(pending_q, rr_ptr_q);
          call_valid_d = 1'b1;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        // Lock withdraws the offer even if the car acks on the same edge.
        if (key_lock_i) begin
          call_valid_d = 1'b0;
          state_d      = LOCKED;
        end else if (call_ack_i) begin
          pending_d    = pending_q & ~(c_one << call_floor_q);
          rr_ptr_d     = (call_floor_q == c_last_floor) ? '0 : call_floor_q + 1'b1;
          call_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      LOCKED: begin
        if (!key_lock_i) state_d = IDLE;
      end
      default: begin
        call_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    // A new press beats a same-edge clear, so that floor is served again.
    pending_d = pending_d | rise_w;
    if (state_q == LOCKED || state_d == LOCKED) pending_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      call_valid_q <= 1'b0;
      call_floor_q <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      btn_q        <= '0;
      hold_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      call_valid_q <= call_valid_d;
      call_floor_q <= call_floor_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      btn_q        <= filt_w[NUM_FLOORS-1:0];
      hold_q       <= hold_d;
      lock_q       <= key_lock_i;
    end
  end

  assign call_valid_o = call_valid_q;
  assign call_floor_o = call_floor_q;
  assign call_lamp_o  = pending_q;
  assign hold_o       = hold_q;
  assign lock_o       = lock_q;

endmodule
`default_nettype wire
